// File: rtl/vga_text_window_if.sv
// Bus bundle for the text window raster engine:
// frame config, colours, glyph memory path and VGA outputs.
interface vga_text_window_if #(
  parameter int RGB_W  = 9,
  parameter int CHAR_W = 8,
  parameter int CHAR_H = 16,
  parameter int COLS   = 16,
  parameter int ROWS   = 4
);
  localparam int CCW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int CRW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int GRW = (CHAR_H > 1) ? $clog2(CHAR_H) : 1;

  logic [9:0]        winX;
  logic [8:0]        winY;
  logic [2:0]        scale;
  logic [RGB_W-1:0]  fgRgb;
  logic [RGB_W-1:0]  bgRgb;
  logic              flashEn;
  logic [CHAR_W-1:0] romByte;
  logic              readEn;
  logic [CCW-1:0]    cellCol;
  logic [CRW-1:0]    cellRow;
  logic [GRW-1:0]    glyphRow;
  logic [RGB_W-1:0]  vgaRGB;
  logic              vgaHsync;
  logic              vgaVsync;

  modport slave (
    input  winX, winY, scale, fgRgb, bgRgb, flashEn, romByte,
    output readEn, cellCol, cellRow, glyphRow,
    output vgaRGB, vgaHsync, vgaVsync
  );

  modport master (
    output winX, winY, scale, fgRgb, bgRgb, flashEn, romByte,
    input  readEn, cellCol, cellRow, glyphRow,
    input  vgaRGB, vgaHsync, vgaVsync
  );
endinterface

// File: rtl/vga_text_window.sv
// VGA raster engine drawing a COLS x ROWS glyph grid at a
// runtime origin and scale, with blink and delay-aligned outputs.
module vga_text_window #(
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter int SYNC_POL     = 0,
  parameter int RGB_W        = 9,
  parameter int CHAR_W       = 8,
  parameter int CHAR_H       = 16,
  parameter int COLS         = 16,
  parameter int ROWS         = 4,
  parameter int MEM_LAT      = 2,
  parameter int FLASH_FRAMES = 30
) (
  input logic clock,
  input logic reset,
  vga_text_window_if.slave bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW  = $clog2(H_TOTAL);
  localparam int VW  = $clog2(V_TOTAL);
  localparam int CCW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int CRW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int GRW = (CHAR_H > 1) ? $clog2(CHAR_H) : 1;
  localparam int BXW = (CHAR_W > 1) ? $clog2(CHAR_W) : 1;
  localparam int FW  = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

  localparam logic [CCW-1:0] CX_LAST = CCW'(COLS - 1);
  localparam logic [CRW-1:0] CY_LAST = CRW'(ROWS - 1);
  localparam logic [GRW-1:0] GY_LAST = GRW'(CHAR_H - 1);
  localparam logic [BXW-1:0] BX_LAST = BXW'(CHAR_W - 1);
  localparam logic [FW-1:0]  FC_LAST = FW'(FLASH_FRAMES - 1);
  localparam logic           SP      = (SYNC_POL != 0);

  typedef struct packed {
    logic           blank;
    logic           win;
    logic           swap;
    logic           hs;
    logic           vs;
    logic [BXW-1:0] bx;
  } pix_t;

  localparam pix_t PIX_IDLE = '{
    blank: 1'b1, win: 1'b0, swap: 1'b0,
    hs: ~SP, vs: ~SP, bx: '0
  };

  logic [HW-1:0]    hCnt_q;
  logic [VW-1:0]    vCnt_q;
  logic [9:0]       winX_q;
  logic [8:0]       winY_q;
  logic [2:0]       scale_q;
  logic             flash_q;
  logic [FW-1:0]    fc_q;
  logic             blink_q;

  logic             vIn_q, vIn_d;
  logic [2:0]       sy_q, sy_d;
  logic [GRW-1:0]   gy_q, gy_d;
  logic [CRW-1:0]   cy_q, cy_d;
  logic             hIn_q, hIn_d;
  logic [2:0]       sx_q, sx_d;
  logic [BXW-1:0]   bx_q, bx_d;
  logic [CCW-1:0]   cx_q, cx_d;

  logic             readEn_q;
  logic [CCW-1:0]   cellCol_q;
  logic [CRW-1:0]   cellRow_q;
  logic [GRW-1:0]   glyphRow_q;

  pix_t             pipe_q [MEM_LAT+1];
  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic             hs_q;
  logic             vs_q;

  logic [31:0]      hc, vc, wx, wy;
  logic             hEnd, vEnd, frameStart;
  logic [9:0]       winX_e;
  logic [8:0]       winY_e;
  logic [2:0]       scale_e, sMax;
  logic             flash_e;
  logic             vStart, vIn, hStart, hIn;
  logic [2:0]       sy, sx;
  logic [GRW-1:0]   gy;
  logic [CRW-1:0]   cy;
  logic [BXW-1:0]   bx;
  logic [CCW-1:0]   cx;
  logic             req;
  pix_t             pix, tap;
  logic [BXW-1:0]   bitIdx;
  logic             bitSel;

  assign hc = 32'(hCnt_q);
  assign vc = 32'(vCnt_q);
  assign hEnd = (hc == 32'(H_TOTAL - 1));
  assign vEnd = (vc == 32'(V_TOTAL - 1));
  assign frameStart = (hCnt_q == '0) && (vCnt_q == '0);

  // Frame config is live on the frame-start cycle, held after.
  assign winX_e  = frameStart ? bus.winX    : winX_q;
  assign winY_e  = frameStart ? bus.winY    : winY_q;
  assign scale_e = frameStart ? bus.scale   : scale_q;
  assign flash_e = frameStart ? bus.flashEn : flash_q;
  assign sMax    = (scale_e == 3'd0) ? 3'd0 : scale_e - 3'd1;
  assign wx = 32'(winX_e);
  assign wy = 32'(winY_e);

  // Line start overrides the held vertical walk state.
  assign vStart = (vc == wy) && (vc < 32'(V_ACTIVE));
  assign vIn = (vStart || vIn_q) && (vc < 32'(V_ACTIVE));
  assign sy  = vStart ? 3'd0 : sy_q;
  assign gy  = vStart ? '0   : gy_q;
  assign cy  = vStart ? '0   : cy_q;

  assign hStart = vIn && (hc == wx) && (hc < 32'(H_ACTIVE));
  assign hIn = vIn && (hc < 32'(H_ACTIVE)) && (hStart || hIn_q);
  assign sx  = hStart ? 3'd0 : sx_q;
  assign bx  = hStart ? '0   : bx_q;
  assign cx  = hStart ? '0   : cx_q;

  assign req = hIn && (sx == 3'd0) && (bx == '0);

  // Raster counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      hCnt_q <= '0;
      vCnt_q <= '0;
    end else begin
      hCnt_q <= hEnd ? '0 : hCnt_q + 1'b1;
      if (hEnd) vCnt_q <= vEnd ? '0 : vCnt_q + 1'b1;
    end
  end

  // Capture window config once per frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      winX_q  <= '0;
      winY_q  <= '0;
      scale_q <= '0;
      flash_q <= 1'b0;
    end else if (frameStart) begin
      winX_q  <= bus.winX;
      winY_q  <= bus.winY;
      scale_q <= bus.scale;
      flash_q <= bus.flashEn;
    end
  end

  // Blink phase flips every FLASH_FRAMES frames.
  always_ff @(posedge clock) begin
    if (reset) begin
      fc_q    <= '0;
      blink_q <= 1'b0;
    end else if (hEnd && vEnd) begin
      if (fc_q == FC_LAST) begin
        fc_q    <= '0;
        blink_q <= ~blink_q;
      end else begin
        fc_q <= fc_q + 1'b1;
      end
    end
  end

  // Vertical walk: replicate line, glyph row, cell row.
  always_comb begin
    vIn_d = vIn_q;
    sy_d  = sy_q;
    gy_d  = gy_q;
    cy_d  = cy_q;
    if (hEnd) begin
      if (vEnd || !vIn) begin
        vIn_d = 1'b0;
        sy_d  = 3'd0;
        gy_d  = '0;
        cy_d  = '0;
      end else begin
        vIn_d = 1'b1;
        sy_d  = sy + 3'd1;
        gy_d  = gy;
        cy_d  = cy;
        if (sy == sMax) begin
          sy_d = 3'd0;
          gy_d = gy + 1'b1;
          if (gy == GY_LAST) begin
            gy_d = '0;
            cy_d = cy + 1'b1;
            if (cy == CY_LAST) begin
              cy_d  = '0;
              vIn_d = 1'b0;
            end
          end
        end
      end
    end
  end

  // Horizontal walk: replicate pixel, glyph bit, cell column.
  always_comb begin
    hIn_d = 1'b0;
    sx_d  = sx;
    bx_d  = bx;
    cx_d  = cx;
    if (hIn) begin
      hIn_d = 1'b1;
      sx_d  = sx + 3'd1;
      if (sx == sMax) begin
        sx_d = 3'd0;
        bx_d = bx + 1'b1;
        if (bx == BX_LAST) begin
          bx_d = '0;
          cx_d = cx + 1'b1;
          if (cx == CX_LAST) begin
            cx_d  = '0;
            hIn_d = 1'b0;
          end
        end
      end
    end
  end

  // Window walk state.
  always_ff @(posedge clock) begin
    if (reset) begin
      vIn_q <= 1'b0;
      sy_q  <= '0;
      gy_q  <= '0;
      cy_q  <= '0;
      hIn_q <= 1'b0;
      sx_q  <= '0;
      bx_q  <= '0;
      cx_q  <= '0;
    end else begin
      vIn_q <= vIn_d;
      sy_q  <= sy_d;
      gy_q  <= gy_d;
      cy_q  <= cy_d;
      hIn_q <= hIn_d;
      sx_q  <= sx_d;
      bx_q  <= bx_d;
      cx_q  <= cx_d;
    end
  end

  // Glyph row request on cell entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      readEn_q   <= 1'b0;
      cellCol_q  <= '0;
      cellRow_q  <= '0;
      glyphRow_q <= '0;
    end else begin
      readEn_q <= req;
      if (req) begin
        cellCol_q  <= cx;
        cellRow_q  <= cy;
        glyphRow_q <= gy;
      end
    end
  end

  always_comb begin
    pix       = PIX_IDLE;
    pix.blank = !((hc < 32'(H_ACTIVE)) && (vc < 32'(V_ACTIVE)));
    pix.win   = hIn;
    pix.swap  = flash_e && blink_q;
    pix.hs    = ~(((hc >= 32'(H_ACTIVE + H_FP)) &&
                   (hc < 32'(H_ACTIVE + H_FP + H_SYNC))) ^ SP);
    pix.vs    = ~(((vc >= 32'(V_ACTIVE + V_FP)) &&
                   (vc < 32'(V_ACTIVE + V_FP + V_SYNC))) ^ SP);
    pix.bx    = bx;
  end

  // Delay line aligning pixel info with romByte.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i <= MEM_LAT; i++) pipe_q[i] <= PIX_IDLE;
    end else begin
      pipe_q[0] <= pix;
      for (int i = 1; i <= MEM_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tap    = pipe_q[MEM_LAT];
  assign bitIdx = BX_LAST - tap.bx;
  assign bitSel = bus.romByte[bitIdx];

  always_comb begin
    rgb_d = '0;
    if (!tap.blank && tap.win) begin
      rgb_d = (bitSel ^ tap.swap) ? bus.fgRgb : bus.bgRgb;
    end
  end

  // Output register.
  always_ff @(posedge clock) begin
    if (reset) begin
      rgb_q <= '0;
      hs_q  <= ~SP;
      vs_q  <= ~SP;
    end else begin
      rgb_q <= rgb_d;
      hs_q  <= tap.hs;
      vs_q  <= tap.vs;
    end
  end

  assign bus.readEn   = readEn_q;
  assign bus.cellCol  = cellCol_q;
  assign bus.cellRow  = cellRow_q;
  assign bus.glyphRow = glyphRow_q;
  assign bus.vgaRGB   = rgb_q;
  assign bus.vgaHsync = hs_q;
  assign bus.vgaVsync = vs_q;
endmodule

// File: tb/tb_vga_text_window.sv
// Randomized bench for vga_text_window on a reduced raster,
// checked against a per-pixel arithmetic reference model.
module tb_vga_text_window;
  localparam int HA = 64, HF = 4, HS = 8, HB = 4;
  localparam int VA = 48, VF = 2, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int RGB_W = 9, CW = 8, CH = 4;
  localparam int COLS = 4, ROWS = 2;
  localparam int ML = 2, FF = 2, LAT = ML + 2;

  typedef struct {
    int wx;
    int wy;
    int sc;
    bit fl;
    int fg;
    int bg;
  } cfg_t;

  typedef struct {
    bit re;
    int c;
    int r;
    int g;
  } req_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int n = 0;
  bit started = 1'b0;
  int n_checks = 0;
  int n_errors = 0;
  int gframe = 0;
  cfg_t cfg [64];
  req_t hist [ML+1];
  logic [CW-1:0] font [ROWS][COLS][CH];

  vga_text_window_if #(
    .RGB_W(RGB_W), .CHAR_W(CW), .CHAR_H(CH),
    .COLS(COLS), .ROWS(ROWS)
  ) bus ();

  vga_text_window #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(0), .RGB_W(RGB_W), .CHAR_W(CW), .CHAR_H(CH),
    .COLS(COLS), .ROWS(ROWS), .MEM_LAT(ML),
    .FLASH_FRAMES(FF)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s n=%0d got %0h expected %0h", tag, n, got, exp);
    end
  endtask

  // Geometry of counter cycle t relative to its frame's window.
  function automatic bit in_win(input int t, output int cx,
                                output int cy, output int gy,
                                output int bx, output int ph);
    int h, v, f, ws, dx, dy;
    h = t % HT;
    v = (t / HT) % VT;
    f = (t / FT) % 64;
    ws = (cfg[f].sc == 0) ? 1 : cfg[f].sc;
    dx = h - cfg[f].wx;
    dy = v - cfg[f].wy;
    cx = 0; cy = 0; gy = 0; bx = 0; ph = 0;
    if (h >= HA || v >= VA || dx < 0 || dy < 0) return 1'b0;
    if (dx >= COLS * CW * ws || dy >= ROWS * CH * ws) return 1'b0;
    cx = dx / (CW * ws);
    bx = (dx / ws) % CW;
    ph = dx % (CW * ws);
    cy = dy / (CH * ws);
    gy = (dy / ws) % CH;
    return 1'b1;
  endfunction

  // Counters reset on any edge with reset high.
  always @(posedge clock) begin
    if (reset) begin
      n <= 0;
      started <= 1'b1;
    end else begin
      n <= n + 1;
    end
  end

  // Glyph memory: returns font data ML cycles after readEn, then holds.
  always @(posedge clock) begin
    #1;
    for (int i = ML; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = '{bus.readEn, int'(bus.cellCol),
                int'(bus.cellRow), int'(bus.glyphRow)};
    if (hist[ML].re)
      bus.romByte = font[hist[ML].r][hist[ML].c][hist[ML].g];
  end

  // Stimulus: new config per frame, junk config mid-frame.
  always @(posedge clock) begin
    #1;
    if (n % FT == 0) begin
      bus.fgRgb   = 9'($urandom);
      bus.bgRgb   = 9'($urandom);
      bus.flashEn = 1'($urandom);
      case (gframe)
        0: begin bus.winX = 10'd10; bus.winY = 9'd3; bus.scale = 3'd1; end
        1: begin bus.winX = 10'd5;  bus.winY = 9'd0; bus.scale = 3'd2; end
        2: begin bus.winX = 10'd70; bus.winY = 9'd4; bus.scale = 3'd1; end
        3: begin bus.winX = 10'd40; bus.winY = 9'd2; bus.scale = 3'd0; end
        default: begin
          bus.winX  = 10'($urandom_range(0, 72));
          bus.winY  = 9'($urandom_range(0, 52));
          bus.scale = 3'($urandom_range(0, 7));
        end
      endcase
      if (!reset) gframe++;
    end else if ($urandom_range(0, 7) == 0) begin
      bus.winX    = 10'($urandom_range(0, 72));
      bus.winY    = 9'($urandom_range(0, 52));
      bus.scale   = 3'($urandom);
      bus.flashEn = 1'($urandom);
    end
  end

  // Record frame config and compare outputs against the model.
  always @(negedge clock) begin
    int t, f, cx, cy, gy, bx, ph, h, v;
    logic [31:0] er;
    bit w, b;
    if (started) begin
      if (n % FT == 0 && n / FT < 64)
        cfg[n / FT] = '{int'(bus.winX), int'(bus.winY),
                        int'(bus.scale), bus.flashEn,
                        int'(bus.fgRgb), int'(bus.bgRgb)};
      t = n - LAT;
      if (t < 0) begin
        check("rgb_rst", 32'(bus.vgaRGB), 32'd0);
        check("hs_rst", 32'(bus.vgaHsync), 32'd1);
        check("vs_rst", 32'(bus.vgaVsync), 32'd1);
      end else begin
        h = t % HT;
        v = (t / HT) % VT;
        f = (t / FT) % 64;
        w = in_win(t, cx, cy, gy, bx, ph);
        er = 0;
        if (w) begin
          b = font[cy][cx][gy][CW-1-bx];
          if (cfg[f].fl && ((t / FT / FF) % 2 == 1)) b = !b;
          er = b ? 32'(cfg[f].fg) : 32'(cfg[f].bg);
        end
        check("rgb", 32'(bus.vgaRGB), er);
        check("hsync", 32'(bus.vgaHsync),
              32'(!(h >= HA + HF && h < HA + HF + HS)));
        check("vsync", 32'(bus.vgaVsync),
              32'(!(v >= VA + VF && v < VA + VF + VS)));
      end
      t = n - 1;
      w = (t >= 0) ? in_win(t, cx, cy, gy, bx, ph) : 1'b0;
      w = w && (ph == 0);
      check("readEn", 32'(bus.readEn), 32'(w));
      if (w) begin
        check("cellCol", 32'(bus.cellCol), 32'(cx));
        check("cellRow", 32'(bus.cellRow), 32'(cy));
        check("glyphRow", 32'(bus.glyphRow), 32'(gy));
      end
    end
  end

  initial begin
    foreach (font[r, c, g]) font[r][c][g] = CW'($urandom);
    font[0][0][0] = 8'hA5;
    for (int i = 0; i <= ML; i++) hist[i] = '{1'b0, 0, 0, 0};
    bus.winX = '0;
    bus.winY = '0;
    bus.scale = '0;
    bus.fgRgb = '0;
    bus.bgRgb = '0;
    bus.flashEn = 1'b0;
    bus.romByte = '0;
    repeat (5) @(posedge clock);
    #1 reset = 1'b0;
    repeat (6 * FT + 123) @(posedge clock);
    #1 reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    repeat (4 * FT + 50) @(posedge clock);
    #2;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/vga_text_window.md
# vga_text_window

Parametrised successor to the display controller: a single-clock VGA raster engine that generates its own sync timing and renders a COLS×ROWS grid of glyph cells at a runtime scale and origin. Glyph bytes come from an external text/font memory path with a fixed latency of MEM_LAT cycles. The block delays sync, blanking and pixel-select so every output stays aligned. It adds hardware flash generation and configurable sync polarity.

## Interface
- H_ACTIVE, 640, visible pixels per line; H_FP 16, H_SYNC 96, H_BP 48
- V_ACTIVE, 480, visible lines; V_FP 10, V_SYNC 2, V_BP 33
- SYNC_POL, 0, 0 = active-low syncs, 1 = active-high
- RGB_W, 9, colour width
- CHAR_W, 8, glyph width in bits (romByte width); CHAR_H 16, glyph rows
- COLS, 16, cells per row; ROWS, 4, cell rows
- MEM_LAT, 2, cycles from readEn to romByte valid (≥1)
- FLASH_FRAMES, 30, frames per blink half-period
- clock  in  1  pixel clock
- reset  in  1  synchronous, active-high
- winX  in  10  window origin pixel; winY  in  9  window origin line
- scale  in  3  pixel replication factor; 0 treated as 1
- fgRgb  in  RGB_W  glyph colour; bgRgb  in  RGB_W  window background
- flashEn  in  1  when 1, swap fg/bg during blink phase
- romByte  in  CHAR_W  glyph row, MSB = leftmost pixel
- readEn  out  1  request strobe for glyph row
- cellCol  out  clog2(COLS); cellRow  out  clog2(ROWS); glyphRow  out  clog2(CHAR_H)
- vgaRGB  out  RGB_W; vgaHsync  out  1; vgaVsync  out  1

## Operation
- hCnt 0..H_TOTAL-1 and vCnt 0..V_TOTAL-1, with H_TOTAL = sum of the H parameters and V_TOTAL likewise. Visible area starts at 0. Sync is asserted for H_SYNC/V_SYNC counts after the front porch.
- winX, winY, scale and flashEn are sampled only when hCnt=0 and vCnt=0 (frame start). They are constant within a frame.
- Horizontal walk uses no divider. At hCnt==winX with the line inside the vertical window, the following reset to 0: sub-pixel counter sx (0..scale-1), bit counter bx (0..CHAR_W-1) and column cx. sx wraps to advance bx; bx wraps to advance cx. The window is exited after cx wraps past COLS-1, or at hCnt==H_ACTIVE, whichever comes first.
- Vertical walk advances sy/gy/cy identically at hCnt==H_TOTAL-1, starting at vCnt==winY. It is exited after row ROWS-1 or at V_ACTIVE.
- Clipping: part of the window beyond the visible area is not drawn. A window starting at or beyond the visible area draws nothing and never raises readEn.
- readEn is raised for one cycle when a cell is entered (bx=0, sx=0), presenting cellCol=cx, cellRow=cy, glyphRow=gy. The bit index bx is delayed by MEM_LAT to select romByte[CHAR_W-1-bx].
- Pixel colour:
  - Outside the window: bgRgb is not used; output is 0.
  - Inside the window: selected bit ? fgRgb : bgRgb. fg and bg swap when flashEn and blink=1.
  - During blanking: 0.
- Blink: a frame counter counts vCnt wraps 0..FLASH_FRAMES-1; blink toggles on each wrap.

## Timing
- Counters, readEn and the address outputs are registered. Address/readEn for the pixel at counter cycle t appear at t+1. romByte is valid at t+1+MEM_LAT. vgaRGB/vgaHsync/vgaVsync are registered at t+MEM_LAT+2.
- Syncs and blank pass through the same delay line, so the total output latency is MEM_LAT+2 for all three outputs.
- Reset (any cycle, including mid-frame) clears on the next edge:
  - counters, window state, frame counter and blink to 0
  - readEn and address outputs to 0, vgaRGB to 0
  - syncs to the inactive level (SYNC_POL ? 0 : 1)
  - all delay-line stages to blank/inactive
- The first sync pulse after reset release is at the nominal position: hsync rises after H_ACTIVE+H_FP counts, plus the latency.
- Simultaneous line and frame wrap: the frame counter and blink update in the same cycle that hCnt and vCnt reach 0.

## Test plan
- Reset held 5 cycles then released, default parameters -> vgaRGB=0, syncs=1 during reset. First hsync low at cycle 656+4 after release, lasting 96 cycles. Line period 800 cycles, frame period 525 lines.
- winX=100, winY=50, scale=1, romByte=8'hA5 constant -> line 50 pixels 100..107 at output show fg,bg,fg,bg,bg,fg,bg,fg. readEn pulses at hCnt 100,108,…,220 (16 pulses), with cellCol 0..15.
- scale=2 -> each bit is 2 pixels wide and each glyph row 2 lines tall. readEn spacing is 16 cycles. glyphRow steps every 2 lines; cellRow steps every 32 lines.
- MEM_LAT=4 build, model returns data exactly 4 cycles after readEn -> same pixel pattern as the previous scenario, shifted by 2 cycles. Syncs are shifted identically.
- flashEn=1, FLASH_FRAMES=2 -> fg/bg swapped in frames 2–3, normal in frames 4–5. A flashEn change mid-frame has no effect until the next frame.
- winX=600, COLS=16 -> only cells 0..4 are drawn and no readEn at hCnt≥640. Reset asserted mid-line -> outputs cleared next edge and timing restarts from hCnt=0.
